axis_split_copy_reg: RTL and testbench
======================================

// Module: axis_split_copy_reg
// PURPOSE
//  Registered, N-way AxiStream duplicator; next generation of the combinational split-copy used between header
//  extraction and the pattern-match/filter stages. Outputs complete handshakes independently (no all-ready coupling).
//  Per-frame output enable mask lets a frame be routed to any subset of consumers or dropped outright.
// PARAMETERS
//  DATA_WIDTH  64  width of data bus, bits
//  OUTPUTS     2   number of output streams, >=1
// PORTS
//  clk             in   1                   clock, all logic rising-edge
//  rst             in   1                   reset, asynchronous, active-high
//  dataIn_data     in   DATA_WIDTH          input beat data
//  dataIn_last     in   1                   last beat of frame
//  dataIn_valid    in   1                   input valid
//  dataIn_ready    out  1                   input ready
//  dataOut_data    out  OUTPUTS*DATA_WIDTH  copy of held data, slice i = output i
//  dataOut_last    out  OUTPUTS             per-output last
//  dataOut_valid   out  OUTPUTS             per-output valid
//  dataOut_ready   in   OUTPUTS             per-output ready
//  out_en          in   OUTPUTS             output enable mask, sampled on first beat of each frame
//  frames_dropped  out  16                  count of frames with empty mask, saturating
// BEHAVIOUR
//  - Reset (async): buf_vld=0, done=0, in_frame=0, mask=0, frames_dropped=0; all dataOut_valid=0, dataIn_ready=1.
//  - Storage: one beat buffer (data, last) + buf_vld + done[OUTPUTS] + frame mask[OUTPUTS].
//  - Input fire = dataIn_valid & dataIn_ready. On fire: load data/last, buf_vld=1, done=~mask_eff (disabled outputs
//    pre-completed). Latency: beat visible on dataOut one cycle after input fire.
//  - mask_eff = out_en when in_frame=0 (first beat), else registered mask. On first-beat fire mask<=out_en.
//    in_frame <= ~dataIn_last on every fire. out_en changes mid-frame have no effect.
//  - dataOut_valid[i] = buf_vld & ~done[i]. Output fire i = valid[i] & ready[i] -> done[i]<=1.
//    valid[i] must not drop and data must not change until fire i (AXI-S stable rule).
//  - all_done_next = &(done | out_fire). dataIn_ready = ~buf_vld | all_done_next (back-to-back beats,
//    full throughput when all enabled outputs ready). When all_done_next and no input fire: buf_vld<=0, done<=0.
//  - Simultaneous last output fire + input fire: buffer reloads same cycle, no bubble.
//  - Empty mask: beat accepted with done=all ones, outputs never assert valid, buffer frees next cycle
//    (frame consumed at up to 1 beat/cycle). frames_dropped +1 on the last beat of such a frame
//    (or first beat when single-beat), saturates at 16'hFFFF.
//  - dataOut_ready with valid low is ignored. Outputs must not combinationally depend on dataIn_valid/data.
//  - OUTPUTS=1: degenerates to a one-beat pipeline register (half rate not allowed; ready path as above).
//  - Reset mid-frame: partial frame discarded, no flush; next accepted beat treated as first beat.
// STRUCTURE
//  - Package axis_split_pkg: localparam DROP_CNT_W=16, function for mask-all-ones, typedef for beat struct {data,last}.
//  - Single file, no sub-module required; the per-output done/valid slice is a generate loop, not a separate module.
//  - Plugs into NetFilter in place of gen_dout_splitCopy_0 with out_en tied to all ones for legacy behaviour.
// TESTING
//  - Reset: assert rst mid-run -> all dataOut_valid=0, dataIn_ready=1, frames_dropped=0 immediately (async).
//  - Throughput: OUTPUTS=2, both ready=1, 8-beat frame data 0..7 -> each output sees 0..7, last on beat 7,
//    dataIn_ready constantly 1, out beat k appears cycle k+1.
//  - Skew: ready0=1, ready1 low for 3 cycles on beat 0xA5 -> out0 fires once, valid0 drops, valid1 holds 0xA5,
//    dataIn_ready=0 for 3 cycles, no duplicate on out0.
//  - Mask: out_en=2'b01 at frame start, switched to 2'b11 mid-frame -> whole 4-beat frame only on out0; next frame
//    on both.
//  - Drop: out_en=0, three 2-beat frames -> no output valid, dataIn_ready never stalls beyond 1 cycle/beat,
//    frames_dropped=3; preload counter 16'hFFFE, drop 2 frames -> 16'hFFFF.
//  - Random: OUTPUTS=3, random valid/ready/out_en, 10k beats -> scoreboard per output matches enabled frames in order.

Source files
------------

// File: rtl/axis_split_pkg.sv
// Shared constants and helpers for the registered AXI-Stream split-copy.
package axis_split_pkg;

    // Width of the saturating dropped-frame counter.
    localparam int unsigned DROP_CNT_W = 16;

    // Upper bound on the number of outputs the helper below can describe.
    localparam int unsigned MAX_OUTPUTS = 64;

    // Mask with the low n bits set; used to build the "every output done" pattern.
    function automatic logic [MAX_OUTPUTS-1:0] low_ones(input int unsigned n);
        logic [MAX_OUTPUTS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_OUTPUTS; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_split_copy_reg.sv
// Registered N-way AXI-Stream duplicator. One beat buffer feeds every output; each output
// completes its own handshake, and a per-frame enable mask selects which outputs see a frame.
module axis_split_copy_reg
    import axis_split_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned OUTPUTS    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         dataIn_data,
    input  logic                          dataIn_last,
    input  logic                          dataIn_valid,
    output logic                          dataIn_ready,
    output logic [OUTPUTS*DATA_WIDTH-1:0] dataOut_data,
    output logic [OUTPUTS-1:0]            dataOut_last,
    output logic [OUTPUTS-1:0]            dataOut_valid,
    input  logic [OUTPUTS-1:0]            dataOut_ready,
    input  logic [OUTPUTS-1:0]            out_en,
    output logic [DROP_CNT_W-1:0]         frames_dropped
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } beat_t;

    localparam logic [MAX_OUTPUTS-1:0] AllOnesWide = low_ones(OUTPUTS);
    localparam logic [OUTPUTS-1:0]     AllOnes     = AllOnesWide[OUTPUTS-1:0];

    beat_t                 buf_q, buf_d;
    logic                  buf_vld_q, buf_vld_d;
    logic [OUTPUTS-1:0]    done_q, done_d;
    logic [OUTPUTS-1:0]    mask_q, mask_d;
    logic                  in_frame_q, in_frame_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [OUTPUTS-1:0]    out_valid;
    logic [OUTPUTS-1:0]    out_fire;
    logic [OUTPUTS-1:0]    mask_eff;
    logic                  in_fire;
    logic                  all_done_next;
    logic                  frame_empty;

    // Per-output slice: valid until that output has taken the held beat.
    for (genvar g = 0; g < OUTPUTS; g++) begin : g_out
        assign out_valid[g]                               = buf_vld_q & ~done_q[g];
        assign out_fire[g]                                = out_valid[g] & dataOut_ready[g];
        assign dataOut_data[g*DATA_WIDTH +: DATA_WIDTH]   = buf_q.data;
        assign dataOut_last[g]                            = buf_q.last;
    end

    assign dataOut_valid  = out_valid;
    assign frames_dropped = drop_cnt_q;

    // The buffer is free this cycle if it is empty or every output finishes now.
    assign all_done_next  = ((done_q | out_fire) == AllOnes);
    assign dataIn_ready   = ~buf_vld_q | all_done_next;
    assign in_fire        = dataIn_valid & dataIn_ready;

    // First beat of a frame uses the live enable; later beats use the captured mask.
    assign mask_eff       = in_frame_q ? mask_q : out_en;
    assign frame_empty    = (mask_eff == '0);

    // Next-state: load on input fire, otherwise retire completed outputs or free the buffer.
    always_comb begin
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        done_d     = done_q | out_fire;
        in_frame_d = in_frame_q;
        mask_d     = mask_q;
        drop_cnt_d = drop_cnt_q;
        if (in_fire) begin
            buf_d.data = dataIn_data;
            buf_d.last = dataIn_last;
            buf_vld_d  = 1'b1;
            // Disabled outputs start out already done so they never raise valid.
            done_d     = ~mask_eff;
            in_frame_d = ~dataIn_last;
            if (!in_frame_q) begin
                mask_d = out_en;
            end
            if (dataIn_last && frame_empty && (drop_cnt_q != '1)) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end else if (buf_vld_q && all_done_next) begin
            buf_vld_d = 1'b0;
            done_d    = '0;
        end
    end

    // State registers, cleared asynchronously so a partial frame is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
            done_q     <= '0;
            mask_q     <= '0;
            in_frame_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            done_q     <= done_d;
            mask_q     <= mask_d;
            in_frame_q <= in_frame_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_axis_split_copy_reg.sv
// Bench for axis_split_copy_reg: cycle tables for the directed cases, hand sequences for
// counter saturation and mid-frame reset, and a per-output scoreboard for random traffic.
module tb_axis_split_copy_reg;

    localparam int unsigned DW = 64;
    localparam int unsigned NO = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    in_data;
    logic             in_last;
    logic             in_valid;
    logic             in_ready;
    logic [NO*DW-1:0] out_data;
    logic [NO-1:0]    out_last;
    logic [NO-1:0]    out_valid;
    logic [NO-1:0]    out_ready;
    logic [NO-1:0]    out_en;
    logic [15:0]      frames_dropped;

    always #5 clk = ~clk;

    axis_split_copy_reg #(
        .DATA_WIDTH (DW),
        .OUTPUTS    (NO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dataIn_data    (in_data),
        .dataIn_last    (in_last),
        .dataIn_valid   (in_valid),
        .dataIn_ready   (in_ready),
        .dataOut_data   (out_data),
        .dataOut_last   (out_last),
        .dataOut_valid  (out_valid),
        .dataOut_ready  (out_ready),
        .out_en         (out_en),
        .frames_dropped (frames_dropped)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // One cycle of stimulus and the outputs expected at the following falling edge.
    typedef struct packed {
        logic          iv;
        logic [63:0]   id;
        logic          il;
        logic [NO-1:0] en;
        logic [NO-1:0] rdy;
        logic          x_ir;
        logic [NO-1:0] x_ov;
        logic [63:0]   x_d;
        logic          x_l;
        logic [15:0]   x_drop;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic iv, input logic [63:0] id, input logic il,
                                input logic [NO-1:0] en, input logic [NO-1:0] rdy,
                                input logic x_ir, input logic [NO-1:0] x_ov,
                                input logic [63:0] x_d, input logic x_l,
                                input logic [15:0] x_drop);
        vec_t v;
        v.iv = iv; v.id = id; v.il = il; v.en = en; v.rdy = rdy;
        v.x_ir = x_ir; v.x_ov = x_ov; v.x_d = x_d; v.x_l = x_l; v.x_drop = x_drop;
        return v;
    endfunction

    task automatic build_vectors();
        // Throughput: 8-beat frame, all outputs ready, beat k visible in cycle k+1.
        for (int k = 0; k < 8; k++)
            vt.push_back(mk(1'b1, 64'(k), k == 7, 3'b111, 3'b111, 1'b1,
                            (k == 0) ? 3'b000 : 3'b111, 64'(k) - 64'd1, 1'b0, 16'd0));
        vt.push_back(mk(1'b0, 64'd0, 1'b0, 3'b111, 3'b111, 1'b1, 3'b111, 64'd7, 1'b1, 16'd0));
        vt.push_back(mk(1'b0, 64'd0, 1'b0, 3'b111, 3'b111, 1'b1, 3'b000, 64'd0, 1'b0, 16'd0));
        // Skew: output 1 stalls three cycles on 0xA5; next beat waits, then reloads with no bubble.
        vt.push_back(mk(1'b1, 64'hA5, 1'b1, 3'b111, 3'b111, 1'b1, 3'b000, 64'h0,  1'b0, 16'd0));
        vt.push_back(mk(1'b1, 64'h5A, 1'b1, 3'b111, 3'b101, 1'b0, 3'b111, 64'hA5, 1'b1, 16'd0));
        vt.push_back(mk(1'b1, 64'h5A, 1'b1, 3'b111, 3'b101, 1'b0, 3'b010, 64'hA5, 1'b1, 16'd0));
        vt.push_back(mk(1'b1, 64'h5A, 1'b1, 3'b111, 3'b101, 1'b0, 3'b010, 64'hA5, 1'b1, 16'd0));
        vt.push_back(mk(1'b1, 64'h5A, 1'b1, 3'b111, 3'b111, 1'b1, 3'b010, 64'hA5, 1'b1, 16'd0));
        vt.push_back(mk(1'b0, 64'h0,  1'b0, 3'b111, 3'b111, 1'b1, 3'b111, 64'h5A, 1'b1, 16'd0));
        vt.push_back(mk(1'b0, 64'h0,  1'b0, 3'b111, 3'b111, 1'b1, 3'b000, 64'h0,  1'b0, 16'd0));
        // Mask: enable changes mid-frame are ignored; the next frame picks up the new enable.
        vt.push_back(mk(1'b1, 64'h10, 1'b0, 3'b001, 3'b111, 1'b1, 3'b000, 64'h0,  1'b0, 16'd0));
        vt.push_back(mk(1'b1, 64'h11, 1'b0, 3'b011, 3'b111, 1'b1, 3'b001, 64'h10, 1'b0, 16'd0));
        vt.push_back(mk(1'b1, 64'h12, 1'b0, 3'b011, 3'b111, 1'b1, 3'b001, 64'h11, 1'b0, 16'd0));
        vt.push_back(mk(1'b1, 64'h13, 1'b1, 3'b011, 3'b111, 1'b1, 3'b001, 64'h12, 1'b0, 16'd0));
        vt.push_back(mk(1'b1, 64'h20, 1'b1, 3'b011, 3'b111, 1'b1, 3'b001, 64'h13, 1'b1, 16'd0));
        vt.push_back(mk(1'b0, 64'h0,  1'b0, 3'b011, 3'b111, 1'b1, 3'b011, 64'h20, 1'b1, 16'd0));
        vt.push_back(mk(1'b0, 64'h0,  1'b0, 3'b011, 3'b111, 1'b1, 3'b000, 64'h0,  1'b0, 16'd0));
        // Drop: three 2-beat frames with an empty mask, accepted every cycle, never shown.
        for (int k = 0; k < 6; k++)
            vt.push_back(mk(1'b1, 64'h30 + 64'(k), k[0], 3'b000, 3'b111, 1'b1, 3'b000,
                            64'h0, 1'b0, 16'(k / 2)));
        vt.push_back(mk(1'b0, 64'h0, 1'b0, 3'b000, 3'b111, 1'b1, 3'b000, 64'h0, 1'b0, 16'd3));
    endtask

    task automatic run_vec(input vec_t v, input int k);
        @(posedge clk); #1;
        in_valid = v.iv; in_data = v.id; in_last = v.il; out_en = v.en; out_ready = v.rdy;
        @(negedge clk);
        check($sformatf("vec%0d in_ready", k), 64'(in_ready), 64'(v.x_ir));
        check($sformatf("vec%0d out_valid", k), 64'(out_valid), 64'(v.x_ov));
        check($sformatf("vec%0d frames_dropped", k), 64'(frames_dropped), 64'(v.x_drop));
        for (int i = 0; i < NO; i++) begin
            if (v.x_ov[i]) begin
                check($sformatf("vec%0d out%0d data", k, i), out_data[i*DW +: DW], v.x_d);
                check($sformatf("vec%0d out%0d last", k, i), 64'(out_last[i]), 64'(v.x_l));
            end
        end
    endtask

    // Scoreboard: expected {last, data} per output, in frame order.
    logic [DW:0]   q0[$];
    logic [DW:0]   q1[$];
    logic [DW:0]   q2[$];
    logic          m_in_frame = 1'b0;
    logic [NO-1:0] m_mask     = '0;

    task automatic pop_cmp(input int i);
        logic [DW:0] e;
        logic        have;
        have = 1'b0;
        e    = '0;
        case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            check($sformatf("out%0d unexpected beat", i), 64'(out_valid[i]), 64'd0);
        end else begin
            check($sformatf("sb out%0d data", i), out_data[i*DW +: DW], e[DW-1:0]);
            check($sformatf("sb out%0d last", i), 64'(out_last[i]), 64'(e[DW]));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                q0.delete(); q1.delete(); q2.delete();
                m_in_frame = 1'b0;
                m_mask     = '0;
            end else begin
                for (int i = 0; i < NO; i++)
                    if (out_valid[i] && out_ready[i]) pop_cmp(i);
                if (in_valid && in_ready) begin
                    logic [NO-1:0] men;
                    men = m_in_frame ? m_mask : out_en;
                    if (!m_in_frame) m_mask = out_en;
                    m_in_frame = !in_last;
                    if (men[0]) q0.push_back({in_last, in_data});
                    if (men[1]) q1.push_back({in_last, in_data});
                    if (men[2]) q2.push_back({in_last, in_data});
                end
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic l, input logic [NO-1:0] en);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_last = l; out_en = en;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready) return;
        end
        check("send in_ready timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic idle_in();
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          beats;
        int          cyc;
        int          flen;
        int          fpos;
        logic        pend;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_ready = '0; out_en = '0;
        build_vectors();
        repeat (3) @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset frames_dropped", 64'(frames_dropped), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int k = 0; k < vt.size(); k++) run_vec(vt[k], k);

        // Saturation: preload near the top, then drop single-beat frames.
        @(negedge clk);
        force dut.drop_cnt_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.drop_cnt_q;
        @(negedge clk);
        check("preload frames_dropped", 64'(frames_dropped), 64'hFFFE);
        send(64'h40, 1'b1, 3'b000);
        send(64'h41, 1'b1, 3'b000);
        idle_in();
        @(negedge clk);
        check("drop to max", 64'(frames_dropped), 64'hFFFF);
        send(64'h42, 1'b1, 3'b000);
        idle_in();
        @(negedge clk);
        check("drop saturates", 64'(frames_dropped), 64'hFFFF);

        // Reset mid-frame: held beat vanishes at once, next beat is a first beat.
        send(64'h50, 1'b0, 3'b001);
        send(64'h51, 1'b0, 3'b001);
        idle_in();
        #2 rst = 1'b1;
        #1;
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst in_ready", 64'(in_ready), 64'd1);
        check("async rst frames_dropped", 64'(frames_dropped), 64'd0);
        @(negedge clk);
        check("rst held out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        send(64'h60, 1'b1, 3'b010);
        idle_in();
        @(negedge clk);
        check("post-rst frame on out1 only", 64'(out_valid), 64'b010);
        repeat (2) @(negedge clk);
        check("post-rst drained", 64'(out_valid), 64'd0);

        // Random traffic: held-valid source, random enables and readies.
        beats = 0; cyc = 0; fpos = 0; flen = $urandom_range(1, 4); pend = 1'b0;
        while (beats < 10000 && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            if (!pend) begin
                if ($urandom_range(0, 3) != 0) begin
                    pend     = 1'b1;
                    in_valid = 1'b1;
                    in_data  = {$urandom, $urandom};
                    in_last  = (fpos == flen - 1);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_en    = NO'($urandom_range(0, 7));
            out_ready = NO'($urandom) | NO'($urandom);
            @(negedge clk);
            if (pend && in_ready) begin
                pend = 1'b0;
                beats++;
                if (in_last) begin
                    fpos = 0;
                    flen = $urandom_range(1, 4);
                end else begin
                    fpos++;
                end
            end
        end
        check("random beats accepted", 64'(beats), 64'd10000);

        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; out_ready = '1;
        repeat (5) @(negedge clk);
        check("q0 drained", 64'(q0.size()), 64'd0);
        check("q1 drained", 64'(q1.size()), 64'd0);
        check("q2 drained", 64'(q2.size()), 64'd0);
        check("final out_valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
